// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder: FSM encoding and register word offsets.
package mmio_port_responder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Word offsets (Address[4:2]) inside the 32-byte window
    localparam logic [2:0] OFF_PORT_OUT   = 3'd0;
    localparam logic [2:0] OFF_PORT_IN    = 3'd1;
    localparam logic [2:0] OFF_EDGE_STAT  = 3'd2;
    localparam logic [2:0] OFF_EDGE_MASK  = 3'd3;
    localparam logic [2:0] OFF_EDGE_COUNT = 3'd4;

    function automatic logic is_mapped(input logic [2:0] woff);
        return woff <= OFF_EDGE_COUNT;
    endfunction

endpackage

// File: rtl/mmio_port_responder_sync.sv
// Two-flop synchronizer per input bit followed by a previous-value flop for rising-edge detection.
module port_sync_edge #(
    parameter int IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] din_i,
    output logic [IN_WIDTH-1:0] sync_o,
    output logic [IN_WIDTH-1:0] rise_o
);

    logic [IN_WIDTH-1:0] meta_q;
    logic [IN_WIDTH-1:0] sync_q;
    logic [IN_WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO target for the processor load/store port: output port, synchronized input port,
// masked rising-edge status/counter and a level interrupt. One response per accepted request.
module mmio_port_responder
    import mmio_port_responder_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = 32'h1001_1000,
    parameter int          IN_WIDTH  = 8,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                Req,
    output logic                Ready,
    output logic                Ack,
    output logic                Err,
    output logic [31:0]         ReadData,
    output logic                Hit,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    state_e               state_q, state_d;
    logic [31:0]          port_out_q, port_out_d;
    logic [IN_WIDTH-1:0]  stat_q, stat_d;
    logic [IN_WIDTH-1:0]  mask_q, mask_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 irq_q, irq_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic [IN_WIDTH-1:0]  in_sync;
    logic [IN_WIDTH-1:0]  in_rise;
    logic [2:0]           woff;
    logic                 accept, mapped, both, wr_en, rd_en;
    logic [31:0]          rd_mux;
    logic                 unused_addr;

    port_sync_edge #(.IN_WIDTH(IN_WIDTH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .din_i  (PortIn),
        .sync_o (in_sync),
        .rise_o (in_rise)
    );

    assign Hit         = (Address[31:5] == MMIO_BASE[31:5]);
    assign unused_addr = ^Address[1:0];
    assign woff        = Address[4:2];
    assign mapped      = is_mapped(woff);
    assign accept      = Req && (state_q == ST_IDLE);
    assign both        = MemRead && MemWrite;
    assign wr_en       = accept && MemWrite && !MemRead && mapped;
    assign rd_en       = MemRead && !MemWrite && mapped;

    always_comb begin
        rd_mux = '0;
        unique case (woff)
            OFF_PORT_OUT:   rd_mux = port_out_q;
            OFF_PORT_IN:    rd_mux[IN_WIDTH-1:0]  = in_sync;
            OFF_EDGE_STAT:  rd_mux[IN_WIDTH-1:0]  = stat_q;
            OFF_EDGE_MASK:  rd_mux[IN_WIDTH-1:0]  = mask_q;
            OFF_EDGE_COUNT: rd_mux[CNT_WIDTH-1:0] = cnt_q;
            default:        rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        port_out_d = port_out_q;
        stat_d     = stat_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            rdata_d = rd_en ? rd_mux : 32'h0;
            err_d   = both || !mapped;
        end

        if (wr_en && woff == OFF_PORT_OUT)  port_out_d = WriteData;
        if (wr_en && woff == OFF_EDGE_MASK) mask_d     = WriteData[IN_WIDTH-1:0];

        // New rising edges are OR'd in after the W1C so a coincident edge survives the clear
        if (wr_en && woff == OFF_EDGE_STAT) stat_d = stat_q & ~WriteData[IN_WIDTH-1:0];
        stat_d = stat_d | in_rise;

        if (wr_en && woff == OFF_EDGE_COUNT)
            cnt_d = '0;
        else if (|(in_rise & mask_q) && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    assign irq_d = |(stat_d & mask_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            port_out_q <= '0;
            stat_q     <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_out_q <= port_out_d;
            stat_q     <= stat_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign Ready    = (state_q == ST_IDLE);
    assign Ack      = (state_q == ST_RESP);
    assign Err      = Ack && err_q;
    assign ReadData = Ack ? rdata_q : 32'h0;
    assign PortOut  = port_out_q;
    assign Irq      = irq_q;

endmodule
